// File: rtl/video_in_pkg.sv
// rtl/video_in_pkg.sv - shared constants and FSM state type for the video_in burst writer
package video_in_pkg;
  localparam int DATA_SIZE   = 32;
  localparam int NB_PACK     = 8;
  localparam int FRAME_WORDS = 76800;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {IDLE, PREP, WRITE, FETCH} bw_state_t;
endpackage

// File: rtl/video_in_addr_gen.sv
// rtl/video_in_addr_gen.sv - frame base latch, per-frame word counter with wrap and frame_done pulse
module video_in_addr_gen #(
  parameter int FRAME_WORDS = video_in_pkg::FRAME_WORDS
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        start,
  input  logic [31:0] frame_base,
  input  logic        advance,
  output logic [31:0] adr,
  output logic        frame_done
);
  localparam int IDX_W = $clog2(FRAME_WORDS);

  logic [31:0]      base_q, base_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;

  always_comb begin
    base_d        = base_q;
    word_idx_d    = word_idx_q;
    frame_start_d = frame_start_q;
    frame_done_d  = 1'b0;
    // frame_base is only sampled at the first burst of a frame
    if (start && frame_start_q) begin
      base_d        = frame_base;
      frame_start_d = 1'b0;
    end
    if (advance) begin
      if (word_idx_q == IDX_W'(FRAME_WORDS - 1)) begin
        word_idx_d    = '0;
        frame_done_d  = 1'b1;
        frame_start_d = 1'b1;
      end else begin
        word_idx_d = word_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      base_q        <= '0;
      word_idx_q    <= '0;
      frame_start_q <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      base_q        <= base_d;
      word_idx_q    <= word_idx_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign adr        = base_q + (32'(word_idx_q) << 2);
  assign frame_done = frame_done_q;
endmodule

// File: rtl/video_in_burst_writer.sv
// rtl/video_in_burst_writer.sv - drains NB_PACK FIFO words per Wishbone write burst into the frame buffer
module video_in_burst_writer
  import video_in_pkg::*;
#(
  parameter int DATA_SIZE   = video_in_pkg::DATA_SIZE,
  parameter int NB_PACK     = video_in_pkg::NB_PACK,
  parameter int FRAME_WORDS = video_in_pkg::FRAME_WORDS
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 enable,
  input  logic [31:0]          frame_base,
  input  logic [DATA_SIZE-1:0] fifo_data,
  input  logic                 fifo_pack_available,
  output logic                 fifo_r_ack,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [31:0]          wb_adr_o,
  output logic [DATA_SIZE-1:0] wb_dat_o,
  output logic [3:0]           wb_sel_o,
  output logic [2:0]           wb_cti_o,
  input  logic                 wb_ack_i,
  output logic                 frame_done
);
  localparam int BEAT_W = $clog2(NB_PACK + 1);

  bw_state_t            state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 fetch_q, fetch_d;
  logic [DATA_SIZE-1:0] dat_q, dat_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic [2:0]           cti_q, cti_d;
  logic                 start;
  logic                 last_beat;

  assign start      = (state_q == IDLE) && enable && fifo_pack_available;
  assign last_beat  = (beat_q == BEAT_W'(NB_PACK - 1));
  assign fifo_r_ack = (state_q == WRITE) && wb_ack_i;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    fetch_d = fetch_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: if (start) state_d = PREP;
      PREP: begin
        dat_d   = fifo_data;
        beat_d  = '0;
        state_d = WRITE;
      end
      WRITE: if (wb_ack_i) begin
        beat_d = beat_q + BEAT_W'(1);
        if (last_beat) begin
          state_d = IDLE;
        end else begin
          state_d = FETCH;
          fetch_d = 1'b0;
        end
      end
      // two-cycle gap covers the FIFO's registered read latency after a pop
      FETCH: begin
        if (fetch_q) begin
          dat_d   = fifo_data;
          fetch_d = 1'b0;
          state_d = WRITE;
        end else begin
          fetch_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    cyc_d = (state_d == WRITE) || (state_d == FETCH);
    stb_d = (state_d == WRITE);
    cti_d = (state_d == WRITE && beat_d == BEAT_W'(NB_PACK - 1)) ? WB_CTI_EOB : WB_CTI_CLASSIC;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      beat_q  <= '0;
      fetch_q <= 1'b0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      cti_q   <= WB_CTI_CLASSIC;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      fetch_q <= fetch_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      cti_q   <= cti_d;
    end
  end

  video_in_addr_gen #(
    .FRAME_WORDS(FRAME_WORDS)
  ) u_addr_gen (
    .clk        (clk),
    .nRST       (nRST),
    .start      (start),
    .frame_base (frame_base),
    .advance    (fifo_r_ack),
    .adr        (wb_adr_o),
    .frame_done (frame_done)
  );

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = cyc_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = 4'hF;
  assign wb_cti_o = cti_q;
endmodule

// File: tb/tb_video_in_burst_writer.sv
// tb/tb_video_in_burst_writer.sv - directed self-checking bench for video_in_burst_writer
module tb_video_in_burst_writer;
  localparam int NB = 8;
  localparam int FW = 16;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] frame_base = '0;
  logic [31:0] fifo_data;
  logic        fifo_pack_available = 1'b0;
  logic        fifo_r_ack;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i = 1'b0;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];
  int          rd_ptr;
  logic [31:0] rec_adr [NB];
  logic [31:0] rec_dat [NB];
  logic [2:0]  rec_cti [NB];
  int          cyc_gap, hold_bad, timeout;
  logic        end_cyc, end_done, end_done2;

  video_in_burst_writer #(
    .DATA_SIZE(32), .NB_PACK(NB), .FRAME_WORDS(FW)
  ) dut (
    .clk(clk), .nRST(nRST), .enable(enable), .frame_base(frame_base),
    .fifo_data(fifo_data), .fifo_pack_available(fifo_pack_available),
    .fifo_r_ack(fifo_r_ack), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);

  // FIFO model: pop at edge E, new head word appears after edge E+1
  always @(posedge clk or negedge nRST)
    if (!nRST) rd_ptr <= 0;
    else if (fifo_r_ack) rd_ptr <= rd_ptr + 1;
  always @(posedge clk) fifo_data <= mem[rd_ptr % 64];

  task automatic service_burst(input int wait_beat, input int wait_n, input int drop_en_beat,
                               input bit drop_pack);
    int cnt, w, beat;
    logic [31:0] sa, sd;
    cyc_gap = 0; hold_bad = 0; timeout = 0; beat = 0; w = 0; cnt = 0; sa = '0; sd = '0;
    while (!wb_cyc_o && cnt < 100) begin @(negedge clk); cnt++; end
    while (beat < NB && cnt < 1000) begin
      if (beat == drop_en_beat) enable = 1'b0;
      if (wb_ack_i) begin
        wb_ack_i = 1'b0;
        beat++;
      end else begin
        if (!wb_cyc_o) cyc_gap++;
        if (wb_stb_o) begin
          if (beat == wait_beat && w < wait_n) begin
            if (w == 0) begin sa = wb_adr_o; sd = wb_dat_o; end
            else if (wb_adr_o !== sa || wb_dat_o !== sd) hold_bad++;
            w++;
          end else begin
            if (beat == wait_beat && (wb_adr_o !== sa || wb_dat_o !== sd)) hold_bad++;
            rec_adr[beat] = wb_adr_o;
            rec_dat[beat] = wb_dat_o;
            rec_cti[beat] = wb_cti_o;
            wb_ack_i = 1'b1;
          end
        end
      end
      if (beat < NB) begin @(negedge clk); cnt++; end
    end
    timeout = (beat < NB) ? 1 : 0;
    end_cyc  = wb_cyc_o;
    end_done = frame_done;
    if (drop_pack) fifo_pack_available = 1'b0;
    @(negedge clk);
    end_done2 = frame_done;
  endtask

  task automatic test_reset();
    int cnt;
    repeat (2) @(negedge clk);
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, frame_done, fifo_r_ack}
        !== {3'b000, 32'h0, 32'h0, 4'hF, 3'b000, 2'b00}) begin
      errors++;
      $display("FAIL reset_outputs cyc %b stb %b adr %h dat %h sel %h cti %b expected all zero sel F",
               wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o);
    end
    nRST = 1'b1;
    frame_base = 32'h1000_0000;
    enable = 1'b1;
    fifo_pack_available = 1'b1;
    cnt = 0;
    while (!wb_stb_o && cnt < 20) begin @(negedge clk); cnt++; end
    wb_ack_i = 1'b1;
    #1;
    checks++;
    if (fifo_r_ack !== 1'b1) begin
      errors++; $display("FAIL reset_pre_ack fifo_r_ack %b expected 1", fifo_r_ack);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, fifo_r_ack, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async cyc %b stb %b r_ack %b done %b expected 0 0 0 0",
               wb_cyc_o, wb_stb_o, fifo_r_ack, frame_done);
    end
    wb_ack_i = 1'b0;
    fifo_pack_available = 1'b0;
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_adr_o !== 32'h0 || rd_ptr != 0) begin
      errors++;
      $display("FAIL reset_release cyc %b adr %h pops %0d expected 0 00000000 0", wb_cyc_o, wb_adr_o, rd_ptr);
    end
  endtask

  task automatic test_single_burst();
    int p0;
    logic [31:0] ea, ed;
    logic [2:0]  ec;
    frame_base = 32'h1000_0000;
    enable = 1'b1;
    fifo_pack_available = 1'b1;
    p0 = rd_ptr;
    service_burst(-1, 0, -1, 1'b1);
    for (int i = 0; i < NB; i++) begin
      ea = 32'h1000_0000 + 32'(4 * i); ed = 32'(1 + i); ec = (i == NB - 1) ? 3'b111 : 3'b000;
      checks++;
      if (rec_adr[i] !== ea || rec_dat[i] !== ed || rec_cti[i] !== ec) begin
        errors++;
        $display("FAIL single_beat%0d adr %h dat %h cti %b expected %h %h %b", i, rec_adr[i], rec_dat[i], rec_cti[i], ea, ed, ec);
      end
    end
    checks++;
    if (rd_ptr - p0 != 8 || cyc_gap != 0 || end_cyc !== 1'b0 || end_done !== 1'b0 || timeout != 0) begin
      errors++;
      $display("FAIL single_burst pops %0d gaps %0d end_cyc %b done %b timeout %0d expected 8 0 0 0 0",
               rd_ptr - p0, cyc_gap, end_cyc, end_done, timeout);
    end
  endtask

  task automatic test_wait_states();
    int p0;
    logic [31:0] ea, ed;
    fifo_pack_available = 1'b1;
    p0 = rd_ptr;
    service_burst(3, 3, -1, 1'b1);
    for (int i = 0; i < NB; i++) begin
      ea = 32'h1000_0020 + 32'(4 * i); ed = 32'(9 + i);
      checks++;
      if (rec_adr[i] !== ea || rec_dat[i] !== ed) begin
        errors++;
        $display("FAIL wait_beat%0d adr %h dat %h expected %h %h", i, rec_adr[i], rec_dat[i], ea, ed);
      end
    end
    checks++;
    if (rd_ptr - p0 != 8 || hold_bad != 0 || cyc_gap != 0 || timeout != 0) begin
      errors++;
      $display("FAIL wait_states pops %0d unstable %0d gaps %0d timeout %0d expected 8 0 0 0",
               rd_ptr - p0, hold_bad, cyc_gap, timeout);
    end
    checks++;
    if (end_done !== 1'b1 || end_done2 !== 1'b0) begin
      errors++; $display("FAIL wait_frame_done pulse %b%b expected 10", end_done, end_done2);
    end
  endtask

  task automatic test_frame_wrap();
    logic [31:0] base [3];
    logic        done [3];
    logic [31:0] ea, ed;
    base[0] = 32'h2000; base[1] = 32'h2020; base[2] = 32'h3000;
    done[0] = 1'b0;     done[1] = 1'b1;     done[2] = 1'b0;
    frame_base = 32'h2000;
    for (int b = 0; b < 3; b++) begin
      if (b == 1) frame_base = 32'h3000;
      fifo_pack_available = 1'b1;
      service_burst(-1, 0, -1, 1'b1);
      for (int i = 0; i < NB; i++) begin
        ea = base[b] + 32'(4 * i); ed = 32'(17 + 8 * b + i);
        checks++;
        if (rec_adr[i] !== ea || rec_dat[i] !== ed) begin
          errors++;
          $display("FAIL wrap_b%0d_beat%0d adr %h dat %h expected %h %h", b, i, rec_adr[i], rec_dat[i], ea, ed);
        end
      end
      checks++;
      if (end_done !== done[b] || end_done2 !== 1'b0 || timeout != 0) begin
        errors++;
        $display("FAIL wrap_b%0d_done pulse %b%b timeout %0d expected %b0 0", b, end_done, end_done2, timeout, done[b]);
      end
    end
  endtask

  task automatic test_no_pack();
    int p0, bad;
    logic [31:0] ea, ed;
    enable = 1'b1;
    fifo_pack_available = 1'b0;
    p0 = rd_ptr; bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (wb_cyc_o !== 1'b0) bad++;
      wb_ack_i = (i == 20);
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    checks++;
    if (bad != 0 || rd_ptr != p0) begin
      errors++; $display("FAIL no_pack_idle cyc_cycles %0d pops %0d expected 0 0", bad, rd_ptr - p0);
    end
    fifo_pack_available = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b0) begin
      errors++; $display("FAIL no_pack_prep cyc %b expected 0", wb_cyc_o);
    end
    @(negedge clk);
    checks++;
    if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin
      errors++; $display("FAIL no_pack_write cyc/stb %b%b expected 11", wb_cyc_o, wb_stb_o);
    end
    service_burst(-1, 0, -1, 1'b1);
    for (int i = 0; i < NB; i++) begin
      ea = 32'h3020 + 32'(4 * i); ed = 32'(41 + i);
      checks++;
      if (rec_adr[i] !== ea || rec_dat[i] !== ed) begin
        errors++;
        $display("FAIL no_pack_beat%0d adr %h dat %h expected %h %h", i, rec_adr[i], rec_dat[i], ea, ed);
      end
    end
  endtask

  task automatic test_enable_drop();
    int bad;
    logic [31:0] ea, ed;
    frame_base = 32'h4000;
    enable = 1'b1;
    fifo_pack_available = 1'b1;
    service_burst(-1, 0, 2, 1'b0);
    for (int i = 0; i < NB; i++) begin
      ea = 32'h4000 + 32'(4 * i); ed = 32'(49 + i);
      checks++;
      if (rec_adr[i] !== ea || rec_dat[i] !== ed) begin
        errors++;
        $display("FAIL enable_beat%0d adr %h dat %h expected %h %h", i, rec_adr[i], rec_dat[i], ea, ed);
      end
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (wb_cyc_o !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || rd_ptr != 56 || timeout != 0) begin
      errors++; $display("FAIL enable_idle cyc_cycles %0d pops %0d timeout %0d expected 0 56 0", bad, rd_ptr, timeout);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_wait_states();
    test_frame_wrap();
    test_no_pack();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
